// File: rtl/mem_wb_pkg.sv
// Shared widths, FSM state and load-size encodings
// for the MEM/WB pipeline register and its helpers.
package mem_wb_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_SEL_W  = 4;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } rd_state_e;

  localparam logic [MEM_SEL_W-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_W-1:0] MEM_SEL_WORD = 4'b1111;

  typedef struct packed {
    logic                  read;
    logic                  sign_ext;
    logic [MEM_SEL_W-1:0]  sel;
    logic [ADDR_W-1:0]     result;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0]     pc;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load alignment: byte lane select with zero/sign extension,
// aligned word pass-through, anything else reads as zero.
module load_align
  import mem_wb_pkg::*;
(
  input  logic [MEM_SEL_W-1:0] sel_i,
  input  logic [1:0]           addr_i,
  input  logic                 sign_ext_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic [DATA_W-1:0]    data_o
);

  logic [7:0] byte_w;

  always_comb begin
    byte_w = data_i[{addr_i, 3'b000} +: 8];
    data_o = '0;
    case (sel_i)
      MEM_SEL_BYTE:
        data_o = {{24{sign_ext_i & byte_w[7]}}, byte_w};
      MEM_SEL_WORD:
        if (addr_i == 2'b00) data_o = data_i;
      default:
        data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: latches MEM results, keeps RAM
// read data stable across stalls, aligns loads, drives WB.
module mem_wb_stage
  import mem_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_current_stage,
  input  logic                  stall_next_stage,
  input  logic                  flush,
  input  logic                  mem_read_flag_in,
  input  logic                  mem_write_flag_in,
  input  logic                  mem_sign_ext_flag_in,
  input  logic [MEM_SEL_W-1:0]  mem_sel_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic                  reg_write_en_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  input  logic [ADDR_W-1:0]     current_pc_addr_in,
  input  logic [DATA_W-1:0]     ram_read_data,
  output logic                  reg_write_en_out,
  output logic [REG_ADDR_W-1:0] reg_write_addr_out,
  output logic [DATA_W-1:0]     reg_write_data_out,
  output logic [ADDR_W-1:0]     current_pc_addr_out
);

  mem_wb_t     stg_q, stg_d;
  rd_state_e   state_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] raw_w;
  logic [DATA_W-1:0] aligned_w;
  logic        bubble_w;
  logic        hold_w;
  logic        unused_wr;

  // Stores need no handling here; the flag is accepted
  // only to keep the MEM bundle uniform.
  assign unused_wr = mem_write_flag_in;

  assign bubble_w = rst | flush
                  | (stall_current_stage & ~stall_next_stage);
  assign hold_w   = stall_current_stage & stall_next_stage;

  always_comb begin
    stg_d = stg_q;
    if (bubble_w) begin
      stg_d = '0;
    end else if (!hold_w) begin
      stg_d.read     = mem_read_flag_in;
      stg_d.sign_ext = mem_sign_ext_flag_in;
      stg_d.sel      = mem_sel_in;
      stg_d.result   = result_in;
      stg_d.we       = reg_write_en_in;
      stg_d.waddr    = reg_write_addr_in;
      stg_d.pc       = current_pc_addr_in;
    end
  end

  always_ff @(posedge clk) begin
    stg_q <= stg_d;
  end

  // RAM data is only valid in the first WB cycle, so a held
  // load snapshots it on the first holding edge.
  always_ff @(posedge clk) begin
    if (bubble_w) begin
      state_q <= LIVE;
      hold_q  <= '0;
    end else if (hold_w) begin
      if (state_q == LIVE && stg_q.read) begin
        state_q <= HELD;
        hold_q  <= ram_read_data;
      end
    end else begin
      state_q <= LIVE;
    end
  end

  assign raw_w = (state_q == HELD) ? hold_q : ram_read_data;

  load_align u_align (
    .sel_i      (stg_q.sel),
    .addr_i     (stg_q.result[1:0]),
    .sign_ext_i (stg_q.sign_ext),
    .data_i     (raw_w),
    .data_o     (aligned_w)
  );

  assign reg_write_en_out    = stg_q.we;
  assign reg_write_addr_out  = stg_q.waddr;
  assign reg_write_data_out  = stg_q.read ? aligned_w
                                          : stg_q.result;
  assign current_pc_addr_out = stg_q.pc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: driver queues expected
// WB outputs per cycle, a negedge monitor compares them.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sc = 1'b0, sn = 1'b0, fl = 1'b0;
  logic        rd = 1'b0, wr = 1'b0, sx = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] res = '0;
  logic        we = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] pc = '0;
  logic [31:0] ram = '0;
  logic        en_o;
  logic [4:0]  a_o;
  logic [31:0] d_o;
  logic [31:0] pc_o;

  int nchk = 0;
  int npass = 0;

  typedef struct {
    longint      t;
    logic        en;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic        rd, wr, sx;
    logic [3:0]  sel;
    logic [31:0] res;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
  } mi_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall_current_stage  (sc),
    .stall_next_stage     (sn),
    .flush                (fl),
    .mem_read_flag_in     (rd),
    .mem_write_flag_in    (wr),
    .mem_sign_ext_flag_in (sx),
    .mem_sel_in           (sel),
    .result_in            (res),
    .reg_write_en_in      (we),
    .reg_write_addr_in    (wa),
    .current_pc_addr_in   (pc),
    .ram_read_data        (ram),
    .reg_write_en_out     (en_o),
    .reg_write_addr_out   (a_o),
    .reg_write_data_out   (d_o),
    .current_pc_addr_out  (pc_o)
  );

  function automatic mi_t nop();
    mi_t m;
    m = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0};
    return m;
  endfunction

  function automatic mi_t alu(logic [31:0] r, logic [4:0] a,
                              logic [31:0] p);
    mi_t m;
    m = '{1'b0, 1'b0, 1'b0, 4'h0, r, 1'b1, a, p};
    return m;
  endfunction

  function automatic mi_t ld(logic s, logic [3:0] z,
                             logic [31:0] r, logic [4:0] a,
                             logic [31:0] p);
    mi_t m;
    m = '{1'b1, 1'b0, s, z, r, 1'b1, a, p};
    return m;
  endfunction

  // One clock: drive MEM inputs + controls + this cycle's RAM
  // data, optionally queue the expected outputs of this cycle.
  task automatic step(input mi_t m, input logic s_c,
                      input logic s_n, input logic f,
                      input logic r, input logic [31:0] rm,
                      input logic chk, input logic e,
                      input logic [4:0] a, input logic [31:0] d,
                      input logic [31:0] p);
    exp_t x;
    rd = m.rd; wr = m.wr; sx = m.sx; sel = m.sel;
    res = m.res; we = m.we; wa = m.wa; pc = m.pc;
    sc = s_c; sn = s_n; fl = f; rst = r; ram = rm;
    if (chk) begin
      x.t = $time + 4;
      x.en = e; x.a = a; x.d = d; x.pc = p;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].t <= $time) begin
      exp_t x;
      x = q.pop_front();
      nchk++;
      if (x.t != $time)
        $display("FAIL missed t=%0d", x.t);
      else if (en_o !== x.en || a_o !== x.a ||
               d_o !== x.d || pc_o !== x.pc)
        $display("FAIL t=%0t got en=%b a=%0d d=%h pc=%h want en=%b a=%0d d=%h pc=%h",
                 $time, en_o, a_o, d_o, pc_o,
                 x.en, x.a, x.d, x.pc);
      else
        npass++;
    end
  end

  localparam logic [3:0] B = 4'b0001;
  localparam logic [3:0] W = 4'b1111;

  initial begin
    @(posedge clk);
    #1;
    // reset state
    step(nop(), 0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(alu(32'h1234, 5'd5, 32'h100),
         0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(ld(1, B, 32'h2003, 5'd6, 32'h104),
         0,0,0,0, 32'h0, 1, 1, 5'd5, 32'h1234, 32'h100);
    step(ld(0, B, 32'h2003, 5'd7, 32'h108),
         0,0,0,0, 32'h80AABBCC, 1, 1, 5'd6, 32'hFFFFFF80, 32'h104);
    step(ld(0, W, 32'h3000, 5'd8, 32'h10C),
         0,0,0,0, 32'h80AABBCC, 1, 1, 5'd7, 32'h00000080, 32'h108);
    // word load held for 3 WB cycles, RAM changes underneath
    step(alu(32'hBAD, 5'd1, 32'hBAD),
         1,1,0,0, 32'hDEADBEEF, 1, 1, 5'd8, 32'hDEADBEEF, 32'h10C);
    step(alu(32'hBAD, 5'd1, 32'hBAD),
         1,1,0,0, 32'h11111111, 1, 1, 5'd8, 32'hDEADBEEF, 32'h10C);
    step(ld(0, W, 32'h3002, 5'd9, 32'h110),
         0,0,0,0, 32'h11111111, 1, 1, 5'd8, 32'hDEADBEEF, 32'h10C);
    // misaligned word -> 0, flush with stall -> bubble
    step(alu(32'h55, 5'd10, 32'h114),
         1,1,1,0, 32'h12345678, 1, 1, 5'd9, 32'h0, 32'h110);
    step(alu(32'h77, 5'd11, 32'h118),
         1,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(nop(), 0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    // reset while HELD
    step(ld(0, W, 32'h4000, 5'd12, 32'h11C),
         0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(nop(), 1,1,0,0, 32'hCAFEF00D,
         1, 1, 5'd12, 32'hCAFEF00D, 32'h11C);
    step(nop(), 1,1,0,0, 32'h0,
         1, 1, 5'd12, 32'hCAFEF00D, 32'h11C);
    step(ld(0, W, 32'h4000, 5'd13, 32'h120),
         0,0,0,1, 32'h0, 1, 1, 5'd12, 32'hCAFEF00D, 32'h11C);
    step(ld(0, W, 32'h4004, 5'd13, 32'h120),
         0,0,0,0, 32'hABCD, 1, 0, 5'd0, 32'h0, 32'h0);
    step(nop(), 0,0,0,0, 32'h13572468,
         1, 1, 5'd13, 32'h13572468, 32'h120);
    // held ALU op stays on result
    step(alu(32'h99, 5'd3, 32'h200),
         0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(nop(), 1,1,0,0, 32'hFFFFFFFF, 1, 1, 5'd3, 32'h99, 32'h200);
    step(nop(), 1,1,0,0, 32'hFFFFFFFF, 1, 1, 5'd3, 32'h99, 32'h200);
    step(nop(), 0,0,0,0, 32'h0, 1, 1, 5'd3, 32'h99, 32'h200);
    // byte lane 1 sign-extended
    step(ld(1, B, 32'h5001, 5'd4, 32'h300),
         0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    step(nop(), 0,0,0,0, 32'h00008000,
         1, 1, 5'd4, 32'hFFFFFF80, 32'h300);
    step(nop(), 0,0,0,0, 32'h0, 1, 0, 5'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    nchk++;
    if (q.size() != 0)
      $display("FAIL drain left=%0d want 0", q.size());
    else
      npass++;
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
